// File: rtl/mdio_pkg.sv
// Shared constants for the Clause-45 MDIO responder.
// Holds the MDIO opcodes, the start and turnaround codes, the frame-bit
// indices and the responder state encoding.
package mdio_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned FLD_W  = 5;

  localparam logic [1:0] OP_ADDR  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_PRIA  = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;
  localparam logic [1:0] ST_C45   = 2'b00;
  localparam logic [1:0] TA_WR    = 2'b10;

  // Frame-bit indices, counted from the first ST bit (k0)
  localparam logic [IDX_W-1:0] K_ST_END  = 5'd1;
  localparam logic [IDX_W-1:0] K_HDR_END = 5'd13;
  localparam logic [IDX_W-1:0] K_TA0     = 5'd14;
  localparam logic [IDX_W-1:0] K_TA_END  = 5'd15;
  localparam logic [IDX_W-1:0] K_LAST    = 5'd31;

  typedef enum logic [2:0] {
    HUNT,
    HDR,
    TA,
    DATA,
    READ,
    SKIP
  } state_t;

endpackage

// File: rtl/mdio_c45_responder.sv
// Clause-45 MDIO MMD responder.
// Decodes address, write, read and post-read-increment frames. Exposes a
// simple register-bank port; the bank itself lives outside this block.
// Ports:
//   mdc, reset            MDIO clock (posedge), asynchronous active-high reset
//   mdio_out, mdio_oe     initiator data and drive enable (undriven line reads as 1)
//   mdio_in, mdio_in_oe   responder data and drive enable toward the initiator
//   reg_addr              current MMD register address
//   wr_data, wr_stb       write data with its one-cycle strobe
//   rd_stb, rd_data       one-cycle read request; rd_data is taken on the next edge
//   frame_err             one-cycle pulse on a malformed frame or a bus conflict
module mdio_c45_responder
  import mdio_pkg::*;
#(
  parameter logic [FLD_W-1:0] PHY_ADDR     = 5'd1,
  parameter logic [FLD_W-1:0] DEV_ADDR     = 5'd1,
  parameter int unsigned      PREAMBLE_LEN = 32
) (
  input  logic              mdc,
  input  logic              reset,
  input  logic              mdio_out,
  input  logic              mdio_oe,
  output logic              mdio_in,
  output logic              mdio_in_oe,
  output logic [DATA_W-1:0] reg_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_stb,
  output logic              rd_stb,
  input  logic [DATA_W-1:0] rd_data,
  output logic              frame_err
);

  localparam int unsigned CNT_W = $clog2(PREAMBLE_LEN + 1);
  localparam logic [CNT_W-1:0] PRE_FULL = CNT_W'(PREAMBLE_LEN);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    pre_q, pre_d;
  logic [DATA_W-2:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   reg_addr_d, wr_data_d;
  logic                mdio_in_d, mdio_in_oe_d, wr_stb_d, rd_stb_d, frame_err_d;
  logic                line;
  logic [DATA_W-1:0]   rx_shift;

  // Line as seen by the responder: the pull-up reads 1 when undriven
  assign line     = ~mdio_oe | mdio_out;
  assign rx_shift = {rx_q, line};

  // Register stage for every piece of state and every output
  always_ff @(posedge mdc or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      idx_q      <= '0;
      pre_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      op_q       <= '0;
      reg_addr   <= '0;
      wr_data    <= '0;
      mdio_in    <= 1'b0;
      mdio_in_oe <= 1'b0;
      wr_stb     <= 1'b0;
      rd_stb     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pre_q      <= pre_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      op_q       <= op_d;
      reg_addr   <= reg_addr_d;
      wr_data    <= wr_data_d;
      mdio_in    <= mdio_in_d;
      mdio_in_oe <= mdio_in_oe_d;
      wr_stb     <= wr_stb_d;
      rd_stb     <= rd_stb_d;
      frame_err  <= frame_err_d;
    end
  end

  // Frame decode: next state and next output values
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q + 5'd1;
    pre_d        = pre_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    op_d         = op_q;
    reg_addr_d   = reg_addr;
    wr_data_d    = wr_data;
    mdio_in_d    = 1'b0;
    mdio_in_oe_d = mdio_in_oe;
    wr_stb_d     = 1'b0;
    rd_stb_d     = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      HUNT: begin
        // The 0 that ends a full preamble is ST bit k0; next edge is k1
        idx_d = IDX_W'(1);
        if (line) begin
          if (pre_q != PRE_FULL) pre_d = pre_q + CNT_W'(1);
        end else begin
          pre_d = '0;
          if (pre_q == PRE_FULL) state_d = HDR;
        end
      end

      HDR: begin
        rx_d = rx_shift[DATA_W-2:0];
        if (idx_q == K_ST_END) begin
          if ({1'b0, line} != ST_C45) begin
            frame_err_d = 1'b1;
            state_d     = SKIP;
          end
        end else if (idx_q == K_HDR_END) begin
          // rx_shift[11:0] holds OP, PRTAD, DEVAD (k2..k13)
          op_d = rx_shift[11:10];
          if (rx_shift[9:5] != PHY_ADDR || rx_shift[4:0] != DEV_ADDR) begin
            state_d = SKIP;
          end else if (rx_shift[11]) begin
            rd_stb_d = 1'b1;
            state_d  = READ;
          end else begin
            state_d = TA;
          end
        end
      end

      TA: begin
        rx_d = rx_shift[DATA_W-2:0];
        if (idx_q == K_TA_END) begin
          if (rx_shift[1:0] != TA_WR) begin
            frame_err_d = 1'b1;
            state_d     = SKIP;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        rx_d = rx_shift[DATA_W-2:0];
        if (idx_q == K_LAST) begin
          if (op_q == OP_WRITE) begin
            wr_data_d = rx_shift;
            wr_stb_d  = 1'b1;
          end else begin
            reg_addr_d = rx_shift;
          end
          state_d = HUNT;
        end
      end

      READ: begin
        // Responder owns the line; an initiator drive here is a conflict
        if (mdio_oe && mdio_in_oe) frame_err_d = 1'b1;
        if (idx_q == K_TA0) begin
          tx_d         = rd_data;
          mdio_in_oe_d = 1'b1;
        end else if (idx_q == K_LAST) begin
          mdio_in_oe_d = 1'b0;
          if (op_q == OP_PRIA) reg_addr_d = reg_addr + DATA_W'(1);
          state_d = HUNT;
        end else begin
          mdio_in_d = tx_q[DATA_W-1];
          tx_d      = {tx_q[DATA_W-2:0], 1'b0};
        end
      end

      SKIP: begin
        if (idx_q == K_LAST) state_d = HUNT;
      end

      default: state_d = HUNT;
    endcase
  end

endmodule

// File: tb/tb_mdio_c45_responder.sv
// Self-checking bench for mdio_c45_responder.
// A frame-level model derives, for every frame bit, what the responder must
// show after that edge; a negedge compare process checks all outputs against
// it, and literal checks after each frame pin the model.
module tb_mdio_c45_responder;

  logic        mdc = 1'b0;
  logic        reset = 1'b0;
  logic        mdio_out = 1'b0;
  logic        mdio_oe = 1'b0;
  logic        mdio_in, mdio_in_oe, wr_stb, rd_stb, frame_err;
  logic [15:0] reg_addr, wr_data;
  logic [15:0] rd_data = 16'h0000;

  mdio_c45_responder dut (
    .mdc        (mdc),
    .reset      (reset),
    .mdio_out   (mdio_out),
    .mdio_oe    (mdio_oe),
    .mdio_in    (mdio_in),
    .mdio_in_oe (mdio_in_oe),
    .reg_addr   (reg_addr),
    .wr_data    (wr_data),
    .wr_stb     (wr_stb),
    .rd_stb     (rd_stb),
    .rd_data    (rd_data),
    .frame_err  (frame_err)
  );

  always #5 mdc = ~mdc;

  int checks = 0;
  int errors = 0;

  // Model expectations for the outputs after the most recent edge
  logic        e_in = 1'b0, e_oe = 1'b0, e_wstb = 1'b0, e_rstb = 1'b0, e_err = 1'b0;
  logic [15:0] m_addr = 16'h0, m_wdata = 16'h0;
  bit          chk_en = 1'b0;

  // Observation counters for literal checks
  int          n_oe = 0, n_wstb = 0, n_rstb = 0, n_err = 0;
  logic [16:0] stream = '0;
  logic [15:0] last_wdata = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge mdc) begin
    if (chk_en) begin
      check("mdio_in",    32'(mdio_in),    32'(e_in));
      check("mdio_in_oe", 32'(mdio_in_oe), 32'(e_oe));
      check("reg_addr",   32'(reg_addr),   32'(m_addr));
      check("wr_data",    32'(wr_data),    32'(m_wdata));
      check("wr_stb",     32'(wr_stb),     32'(e_wstb));
      check("rd_stb",     32'(rd_stb),     32'(e_rstb));
      check("frame_err",  32'(frame_err),  32'(e_err));
    end
  end

  always @(negedge mdc) begin
    if (mdio_in_oe) begin
      n_oe++;
      stream = {stream[15:0], mdio_in};
    end
    if (wr_stb) begin
      n_wstb++;
      last_wdata = wr_data;
    end
    if (rd_stb) n_rstb++;
    if (frame_err) n_err++;
  end

  task automatic clr_mon();
    n_oe = 0; n_wstb = 0; n_rstb = 0; n_err = 0; stream = '0;
  endtask

  task automatic clear_pulses();
    e_wstb = 1'b0; e_rstb = 1'b0; e_err = 1'b0;
  endtask

  task automatic drive_bit(input logic oe, input logic val);
    @(negedge mdc);
    mdio_oe  = oe;
    mdio_out = val;
    @(posedge mdc);
    #1;
  endtask

  // Idle with the line driven low so no stray preamble builds up
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive_bit(1'b1, 1'b0);
      clear_pulses();
    end
  endtask

  task automatic do_abort();
    @(negedge mdc);
    mdio_oe = 1'b1; mdio_out = 1'b0;
    #2;
    check("oe_before_abort", 32'(mdio_in_oe), 32'd1);
    reset = 1'b1;
    #1;
    check("oe_async_drop", 32'(mdio_in_oe), 32'd0);
    m_addr = 16'h0; m_wdata = 16'h0;
    e_in = 1'b0; e_oe = 1'b0;
    clear_pulses();
    repeat (2) @(posedge mdc);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_frame(input int pre_len, input logic [1:0] st, input logic [1:0] op,
                            input logic [4:0] prtad, input logic [4:0] devad,
                            input logic [1:0] ta, input logic [15:0] data,
                            input logic [15:0] rdv, input int conflict_k, input int abort_k);
    logic [31:0] fb;
    logic        oe, b;
    bit          pre_ok, st_ok, match, is_rd;
    fb     = {st, op, prtad, devad, ta, data};
    pre_ok = (pre_len >= 32);
    st_ok  = (st == 2'b00);
    match  = (prtad == 5'd1) && (devad == 5'd1);
    is_rd  = op[1];
    rd_data = rdv;
    for (int i = 0; i < pre_len; i++) begin
      drive_bit(1'b1, 1'b1);
      clear_pulses();
    end
    for (int k = 0; k < 32; k++) begin
      if (is_rd && k >= 14) begin
        oe = (k == conflict_k);
        b  = 1'b0;
      end else begin
        oe = 1'b1;
        b  = fb[31-k];
      end
      if (k == abort_k) begin
        do_abort();
        return;
      end
      drive_bit(oe, b);
      clear_pulses();
      if (pre_ok) begin
        if (!st_ok) begin
          if (k == 1) e_err = 1'b1;
        end else if (match) begin
          if (is_rd) begin
            if (k == 13) e_rstb = 1'b1;
            if (k == 14) begin
              e_oe = 1'b1; e_in = 1'b0;
            end else if (k >= 15 && k <= 30) begin
              e_in = rdv[30-k];
            end else if (k == 31) begin
              e_oe = 1'b0; e_in = 1'b0;
              if (op == 2'b10) m_addr = m_addr + 16'd1;
            end
            if (k == conflict_k && k >= 15) e_err = 1'b1;
          end else begin
            if (k == 15 && ta != 2'b10) e_err = 1'b1;
            if (k == 31 && ta == 2'b10) begin
              if (op == 2'b00) m_addr = data;
              else begin
                m_wdata = data;
                e_wstb  = 1'b1;
              end
            end
          end
        end
      end
    end
  endtask

  initial begin
    // 1: reset window
    #20;
    reset  = 1'b1;
    #1;
    chk_en = 1'b1;
    #109;
    check("rst_reg_addr", 32'(reg_addr), 32'h0);
    check("rst_oe", 32'(mdio_in_oe), 32'h0);
    #10;
    reset = 1'b0;
    idle(3);
    clr_mon();

    // 2: address frame
    send_frame(32, 2'b00, 2'b00, 5'd1, 5'd1, 2'b10, 16'h0010, 16'h0, -1, -1);
    idle(2);
    check("addr_reg", 32'(reg_addr), 32'h0010);
    check("addr_no_wstb", 32'(n_wstb), 32'd0);
    check("addr_no_rstb", 32'(n_rstb), 32'd0);
    clr_mon();

    // 3: write frame
    send_frame(32, 2'b00, 2'b01, 5'd1, 5'd1, 2'b10, 16'hBEEF, 16'h0, -1, -1);
    idle(2);
    check("wr_stb_count", 32'(n_wstb), 32'd1);
    check("wr_data_val", 32'(last_wdata), 32'hBEEF);
    check("wr_addr_kept", 32'(reg_addr), 32'h0010);
    clr_mon();

    // 4: read frame
    send_frame(34, 2'b00, 2'b11, 5'd1, 5'd1, 2'b00, 16'h0, 16'h2468, -1, -1);
    idle(2);
    check("rd_stb_count", 32'(n_rstb), 32'd1);
    check("rd_oe_cycles", 32'(n_oe), 32'd17);
    check("rd_stream", 32'(stream), 32'h02468);
    check("rd_no_err", 32'(n_err), 32'd0);
    clr_mon();

    // 5: post-read-increment at the top of the address space
    send_frame(32, 2'b00, 2'b00, 5'd1, 5'd1, 2'b10, 16'hFFFF, 16'h0, -1, -1);
    idle(2);
    clr_mon();
    send_frame(32, 2'b00, 2'b10, 5'd1, 5'd1, 2'b00, 16'h0, 16'h1357, -1, -1);
    idle(2);
    check("pria_stream", 32'(stream), 32'h01357);
    check("pria_wrap", 32'(reg_addr), 32'h0000);
    clr_mon();

    // 6a: PRTAD mismatch
    send_frame(32, 2'b00, 2'b11, 5'd2, 5'd1, 2'b00, 16'h0, 16'hAAAA, -1, -1);
    idle(2);
    check("mis_no_oe", 32'(n_oe), 32'd0);
    check("mis_no_rstb", 32'(n_rstb), 32'd0);
    check("mis_no_err", 32'(n_err), 32'd0);
    clr_mon();

    // 6b: Clause-22 start code
    send_frame(32, 2'b01, 2'b01, 5'd1, 5'd1, 2'b10, 16'h1234, 16'h0, -1, -1);
    idle(2);
    check("st_err_pulse", 32'(n_err), 32'd1);
    check("st_no_wstb", 32'(n_wstb), 32'd0);
    clr_mon();

    // 6c: preamble one bit short
    send_frame(31, 2'b00, 2'b01, 5'd1, 5'd1, 2'b10, 16'h5555, 16'h0, -1, -1);
    idle(2);
    check("short_no_wstb", 32'(n_wstb), 32'd0);
    check("short_no_err", 32'(n_err), 32'd0);
    clr_mon();

    // 6d: bad turnaround on a write
    send_frame(32, 2'b00, 2'b01, 5'd1, 5'd1, 2'b11, 16'h7777, 16'h0, -1, -1);
    idle(2);
    check("ta_err_pulse", 32'(n_err), 32'd1);
    check("ta_no_wstb", 32'(n_wstb), 32'd0);
    clr_mon();

    // 6e: initiator drives during the read data phase
    send_frame(32, 2'b00, 2'b11, 5'd1, 5'd1, 2'b00, 16'h0, 16'h0F0F, 20, -1);
    idle(2);
    check("conf_err_pulse", 32'(n_err), 32'd1);
    check("conf_oe_cycles", 32'(n_oe), 32'd17);
    check("conf_stream", 32'(stream), 32'h00F0F);
    clr_mon();

    // 6f: reset at k20 of a read, then a normal frame
    send_frame(32, 2'b00, 2'b11, 5'd1, 5'd1, 2'b00, 16'h0, 16'hC3C3, -1, 20);
    idle(2);
    clr_mon();
    send_frame(32, 2'b00, 2'b00, 5'd1, 5'd1, 2'b10, 16'h00A5, 16'h0, -1, -1);
    idle(2);
    check("post_rst_addr", 32'(reg_addr), 32'h00A5);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
